input_controller: RTL and testbench

- Sits between the processor's INPUT instruction path and the board inputs: 6 buttons, 8 switches, 4×8 GPIO pins.
- Synchronises and debounces the raw pins and captures button presses so short presses are not missed.
- Serves processor read requests for one input index at a time over a req/ack handshake.

---
 rtl/input_pkg.sv | 24 ++
 rtl/input_debounce.sv | 63 ++++++
 rtl/input_controller.sv | 160 ++++++++++++++++
 tb/tb_input_controller.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/input_pkg.sv
// Shared constants and FSM state type for the input controller.
// Index map of the 46-bit input vector, address width and read states.
package input_pkg;

    localparam int unsigned NUM_INPUTS = 46;
    localparam int unsigned ADDR_W     = 6;
    localparam int unsigned DATA_W     = 16;
    localparam int unsigned NUM_BTN    = 6;
    localparam int unsigned NUM_DB     = 14;

    localparam int unsigned BTN_BASE   = 0;
    localparam int unsigned SW_BASE    = 6;
    localparam int unsigned GPIO6_BASE = 14;
    localparam int unsigned GPIO7_BASE = 22;
    localparam int unsigned GPIO8_BASE = 30;
    localparam int unsigned GPIO9_BASE = 38;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage

// File: rtl/input_debounce.sv
// Per-bit synchroniser, sample history and stable-level filter for
// active-low board inputs.
//   clk, rst_n : clock, async active-low reset
//   tick       : shared sample strobe (one cycle wide)
//   raw_n      : raw active-low pins
//   level      : debounced, polarity-corrected (active-high) level
module input_debounce #(
    parameter int unsigned WIDTH   = 14,
    parameter int unsigned SAMPLES = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tick,
    input  logic [WIDTH-1:0] raw_n,
    output logic [WIDTH-1:0] level
);

    logic [WIDTH-1:0]              sync1;
    logic [WIDTH-1:0]              sync2;
    logic [WIDTH-1:0]              sample_c;
    logic [WIDTH-1:0][SAMPLES-1:0] hist;
    logic [WIDTH-1:0][SAMPLES-1:0] hist_next_c;

    // Inversion after the synchroniser: pressed/closed reads as 1.
    assign sample_c = ~sync2;

    // History with the current sample shifted in at the LSB.
    always_comb begin
        hist_next_c = hist;
        for (int i = 0; i < int'(WIDTH); i++) begin
            hist_next_c[i] = (hist[i] << 1) | SAMPLES'(sample_c[i]);
        end
    end

    // Two-flop synchroniser.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw_n;
            sync2 <= sync1;
        end
    end

    // Level moves only once the whole history agrees.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist  <= '0;
            level <= '0;
        end else if (tick) begin
            hist <= hist_next_c;
            for (int i = 0; i < int'(WIDTH); i++) begin
                if (&hist_next_c[i]) begin
                    level[i] <= 1'b1;
                end else if (~|hist_next_c[i]) begin
                    level[i] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/input_controller.sv
// Board input controller: synchronises/debounces buttons and switches,
// synchronises GPIO, latches button presses and answers single-bit reads.
//   clk, rst_n          : clock, async active-low reset
//   buttons[5:0]        : raw buttons, active-low
//   switches[7:0]       : raw switches, active-low
//   gpio_p6..gpio_p9    : raw GPIO, active-high
//   rd_req, rd_addr     : read request (level) and input index
//   rd_ack, rd_data     : one-cycle ack with zero-extended bit
//   inputs_now[45:0]    : {gpio_p9, gpio_p8, gpio_p7, gpio_p6, switches, buttons}
//   irq                 : only with INPUT_IRQ_EN, high while any press is latched
module input_controller
    import input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_TICKS   = 16'd50000,
    parameter int unsigned DEBOUNCE_SAMPLES = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_BTN-1:0]    buttons,
    input  logic [7:0]            switches,
    input  logic [7:0]            gpio_p6,
    input  logic [7:0]            gpio_p7,
    input  logic [7:0]            gpio_p8,
    input  logic [7:0]            gpio_p9,
    input  logic                  rd_req,
    input  logic [ADDR_W-1:0]     rd_addr,
    output logic                  rd_ack,
    output logic [DATA_W-1:0]     rd_data,
    output logic [NUM_INPUTS-1:0] inputs_now
`ifdef INPUT_IRQ_EN
   ,output logic                  irq
`endif
);

    logic [15:0]         presc;
    logic                tick_c;
    logic [NUM_DB-1:0]   db_level;
    logic [31:0]         gpio_s1;
    logic [31:0]         gpio_s2;
    logic [NUM_BTN-1:0]  btn_prev;
    logic [NUM_BTN-1:0]  press;
    logic [NUM_BTN-1:0]  clr_c;
    logic [NUM_BTN-1:0]  press_next_c;
    logic                lookup_bit_c;
    state_t              state;
    logic [ADDR_W-1:0]   addr_q;

    // Free-running sample prescaler.
    assign tick_c = (presc == DEBOUNCE_TICKS - 16'd1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc <= '0;
        end else begin
            presc <= tick_c ? 16'd0 : presc + 16'd1;
        end
    end

    input_debounce #(
        .WIDTH   (NUM_DB),
        .SAMPLES (DEBOUNCE_SAMPLES)
    ) u_debounce (
        .clk   (clk),
        .rst_n (rst_n),
        .tick  (tick_c),
        .raw_n ({switches, buttons}),
        .level (db_level)
    );

    // GPIO is synchronised only, no debounce or inversion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gpio_s1 <= '0;
            gpio_s2 <= '0;
        end else begin
            gpio_s1 <= {gpio_p9, gpio_p8, gpio_p7, gpio_p6};
            gpio_s2 <= gpio_s1;
        end
    end

    assign inputs_now[BTN_BASE   +: NUM_DB] = db_level;
    assign inputs_now[GPIO6_BASE +: 8]      = gpio_s2[7:0];
    assign inputs_now[GPIO7_BASE +: 8]      = gpio_s2[15:8];
    assign inputs_now[GPIO8_BASE +: 8]      = gpio_s2[23:16];
    assign inputs_now[GPIO9_BASE +: 8]      = gpio_s2[31:24];

    // Press latch: a rising edge in the same cycle as a clear wins.
    always_comb begin
        clr_c = '0;
        for (int i = 0; i < int'(NUM_BTN); i++) begin
            clr_c[i] = (state == RESP) && (addr_q == ADDR_W'(i));
        end
        press_next_c = (press & ~clr_c) | (db_level[NUM_BTN-1:0] & ~btn_prev);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            btn_prev <= '0;
            press    <= '0;
        end else begin
            btn_prev <= db_level[NUM_BTN-1:0];
            press    <= press_next_c;
        end
    end

    // Selected bit for the captured address; out-of-range reads as 0.
    always_comb begin
        lookup_bit_c = 1'b0;
        if (addr_q < ADDR_W'(SW_BASE)) begin
            lookup_bit_c = inputs_now[addr_q[2:0]] | press[addr_q[2:0]];
        end else if (addr_q < ADDR_W'(NUM_INPUTS)) begin
            lookup_bit_c = inputs_now[addr_q];
        end
    end

    // Read handshake: IDLE -> LOOKUP -> RESP, ack high during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            rd_ack  <= 1'b0;
            rd_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    rd_ack <= 1'b0;
                    if (rd_req) begin
                        addr_q <= rd_addr;
                        state  <= LOOKUP;
                    end
                end
                LOOKUP: begin
                    rd_ack  <= 1'b1;
                    rd_data <= DATA_W'(lookup_bit_c);
                    state   <= RESP;
                end
                RESP: begin
                    rd_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: begin
                    rd_ack <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

`ifdef INPUT_IRQ_EN
    // Tracks the latch set itself, so it falls together with the last clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            irq <= 1'b0;
        end else begin
            irq <= |press_next_c;
        end
    end
`endif

endmodule

// File: tb/tb_input_controller.sv
// Directed bench for input_controller with a short debounce period.
module tb_input_controller;

    localparam int TICKS = 4;

    logic        clk;
    logic        rst_n;
    logic [5:0]  buttons;
    logic [7:0]  switches;
    logic [7:0]  gpio_p6, gpio_p7, gpio_p8, gpio_p9;
    logic        rd_req;
    logic [5:0]  rd_addr;
    logic        rd_ack;
    logic [15:0] rd_data;
    logic [45:0] inputs_now;
`ifdef INPUT_IRQ_EN
    logic        irq;
`endif

    int checks = 0;
    int errors = 0;
    int cyc;
    logic [15:0] exp_q[$];

    input_controller #(
        .DEBOUNCE_TICKS   (16'd4),
        .DEBOUNCE_SAMPLES (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .buttons    (buttons),
        .switches   (switches),
        .gpio_p6    (gpio_p6),
        .gpio_p7    (gpio_p7),
        .gpio_p8    (gpio_p8),
        .gpio_p9    (gpio_p9),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .inputs_now (inputs_now)
`ifdef INPUT_IRQ_EN
       ,.irq        (irq)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Rising edges since reset release; every TICKS-th edge is a sample tick.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end by itself");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", name, got, exp);
        end
    endtask

    // Advance to just after the n-th following tick edge.
    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            while (cyc % TICKS != 0) @(negedge clk);
        end
    endtask

    // Called at a negedge with the FSM idle; returns one cycle after the ack.
    task automatic do_read(input logic [5:0] addr, input logic [15:0] exp, input string name);
        int n;
        bit got;
        logic [15:0] e;
        rd_req  = 1'b1;
        rd_addr = addr;
        exp_q.push_back(exp);
        n   = 0;
        got = 1'b0;
        while (!got && n < 6) begin
            @(negedge clk);
            n++;
            if (n == 1) rd_addr = ~addr;
            if (rd_ack === 1'b1) got = 1'b1;
        end
        check({name, "_latency"}, 64'(n), 64'd2);
        rd_req = 1'b0;
        e = exp_q.pop_front();
        if (got) check({name, "_data"}, 64'(rd_data), 64'(e));
        @(negedge clk);
        check({name, "_ack_drop"}, 64'(rd_ack), 64'd0);
        check({name, "_hold"}, 64'(rd_data), 64'(e));
    endtask

    initial begin
        rst_n    = 1'b0;
        buttons  = 6'h3F;
        switches = 8'hFF;
        gpio_p6  = 8'h00;
        gpio_p7  = 8'h00;
        gpio_p8  = 8'h00;
        gpio_p9  = 8'h00;
        rd_req   = 1'b0;
        rd_addr  = 6'd0;
        repeat (3) @(negedge clk);
        check("reset_ack", 64'(rd_ack), 64'd0);
        check("reset_data", 64'(rd_data), 64'd0);
        check("reset_inputs", 64'(inputs_now), 64'd0);
        rst_n = 1'b1;

        // GPIO path and a nonzero rd_data ahead of the reset test
        gpio_p6 = 8'h01;
        repeat (3) @(negedge clk);
        check("gpio6_vec", 64'(inputs_now), 64'h4000);
        do_read(6'd14, 16'h0001, "gpio6_b0");

        // Latch button 2, then reset while a read of it is in LOOKUP
        wait_ticks(1);
        buttons[2] = 1'b0;
        wait_ticks(3);
        check("btn2_level_on", 64'(inputs_now[2]), 64'd1);
        buttons[2] = 1'b1;
        wait_ticks(4);
        check("btn2_level_off", 64'(inputs_now[2]), 64'd0);
        gpio_p6 = 8'h00;
        rd_req  = 1'b1;
        rd_addr = 6'd2;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midreq_reset_ack", 64'(rd_ack), 64'd0);
        check("midreq_reset_data", 64'(rd_data), 64'd0);
        check("midreq_reset_inputs", 64'(inputs_now), 64'd0);
        rd_req = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_ack", 64'(rd_ack), 64'd0);
        do_read(6'd2, 16'h0000, "btn2_latch_cleared");

        // Switch 2 held for four ticks
        wait_ticks(1);
        switches[2] = 1'b0;
        wait_ticks(2);
        check("sw2_after2", 64'(inputs_now[8]), 64'd0);
        wait_ticks(1);
        check("sw2_after3", 64'(inputs_now[8]), 64'd1);
        do_read(6'd8, 16'h0001, "sw2");
        wait_ticks(1);
        switches[2] = 1'b1;
        wait_ticks(4);
        check("sw2_release", 64'(inputs_now[8]), 64'd0);

        // Button 1 glitch lasting one sample
        wait_ticks(1);
        buttons[1] = 1'b0;
        wait_ticks(1);
        buttons[1] = 1'b1;
        wait_ticks(3);
        check("btn1_glitch_level", 64'(inputs_now[1]), 64'd0);
        do_read(6'd1, 16'h0000, "btn1_glitch");

        // Button 3 short press, read twice
        wait_ticks(1);
        buttons[3] = 1'b0;
        wait_ticks(3);
        check("btn3_level_on", 64'(inputs_now[3]), 64'd1);
        buttons[3] = 1'b1;
        wait_ticks(4);
        check("btn3_level_off", 64'(inputs_now[3]), 64'd0);
        do_read(6'd3, 16'h0001, "btn3_first");
        do_read(6'd3, 16'h0000, "btn3_second");

        // Button 0 edge lands in the RESP cycle of a read of addr 0
        wait_ticks(1);
        buttons[0] = 1'b0;
        repeat (10) @(negedge clk);
        do_read(6'd0, 16'h0000, "btn0_edge_in_resp");
        buttons[0] = 1'b1;
        wait_ticks(4);
        check("btn0_level_off", 64'(inputs_now[0]), 64'd0);
        do_read(6'd0, 16'h0001, "btn0_latch_kept");
        do_read(6'd0, 16'h0000, "btn0_cleared");

        // Top GPIO bit and out-of-range addresses
        gpio_p9 = 8'h80;
        repeat (3) @(negedge clk);
        check("gpio9_vec", 64'(inputs_now), 64'h2000_0000_0000);
        do_read(6'd45, 16'h0001, "gpio9_b7");
        do_read(6'd44, 16'h0000, "gpio9_b6");
        gpio_p9 = 8'hFF;
        repeat (3) @(negedge clk);
        do_read(6'd46, 16'h0000, "addr46");
        do_read(6'd63, 16'h0000, "addr63");
        gpio_p9 = 8'h00;

`ifdef INPUT_IRQ_EN
        check("irq_idle", 64'(irq), 64'd0);
        wait_ticks(1);
        buttons[5] = 1'b0;
        wait_ticks(3);
        @(negedge clk);
        check("irq_set", 64'(irq), 64'd1);
        buttons[5] = 1'b1;
        wait_ticks(4);
        check("irq_held", 64'(irq), 64'd1);
        do_read(6'd5, 16'h0001, "btn5_irq");
        check("irq_cleared", 64'(irq), 64'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
